// File: rtl/pwm_carrier_sched_pkg.sv
// Shared types for the PWM carrier path: channel enable type, counter and
// load-mode encodings, and the shadow->active load-event decode.
`ifndef PWMCOUNT_WIDTH
`define PWMCOUNT_WIDTH 16
`endif

package pwm_carrier_sched_pkg;

  localparam int unsigned PWM_CW = `PWMCOUNT_WIDTH;

  typedef logic _pwm_onoff;

  typedef enum logic [1:0] {
    CNT_UP     = 2'd0,
    CNT_DOWN   = 2'd1,
    CNT_UPDOWN = 2'd2,
    CNT_HOLD   = 2'd3
  } cnt_mode_e;

  typedef enum logic [1:0] {
    LD_ZERO   = 2'd0,
    LD_PERIOD = 2'd1,
    LD_BOTH   = 2'd2,
    LD_IMM    = 2'd3
  } load_mode_e;

  // True when the selected load event is present on the current carrier.
  function automatic logic load_cond(input load_mode_e mode,
                                     input logic       at_zero,
                                     input logic       at_period);
    logic hit;
    case (mode)
      LD_ZERO:   hit = at_zero;
      LD_PERIOD: hit = at_period;
      LD_BOTH:   hit = at_zero | at_period;
      LD_IMM:    hit = 1'b1;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/compare_16bits.sv
// Unsigned magnitude comparator used by the PWM compare stage (a < b).
module compare_16bits #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         lt
);

  assign lt = (a < b);

endmodule

// File: rtl/pwm_carrier_sched.sv
// Per-channel PWM carrier generator with double-buffered period/compare
// registers and a registered, enable-gated comparator output.
module pwm_carrier_sched
  import pwm_carrier_sched_pkg::*;
#(
  parameter int unsigned CW = `PWMCOUNT_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  _pwm_onoff     pwm_onoff,
  input  logic [1:0]    count_mode,
  input  logic [1:0]    load_mode,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [CW-1:0] period_in,
  input  logic [CW-1:0] compare_in,
  output logic [CW-1:0] carrier,
  output logic [CW-1:0] compare_act,
  output logic          dir,
  output logic          evt_zero,
  output logic          evt_period,
  output logic          load_evt,
  output logic          pwm
);

  localparam logic [CW-1:0] ZERO_C = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_C  = {{(CW-1){1'b0}}, 1'b1};

  cnt_mode_e     cnt_mode_s;
  load_mode_e    ld_mode_s;

  logic [CW-1:0] carrier_r;
  logic          dir_r;
  logic [CW-1:0] period_act_r;
  logic [CW-1:0] compare_act_r;
  logic [CW-1:0] period_sh_r;
  logic [CW-1:0] compare_sh_r;
  logic          pending_r;
  logic          wr_ready_r;
  logic          load_evt_r;
  logic          pwm_r;

  logic          at_zero_s;
  logic          at_period_s;
  logic          over_s;
  logic          wr_acc_s;
  logic          force_xfer_s;
  logic          xfer_s;
  logic          cmp_lt_s;
  logic [CW-1:0] carrier_nxt_s;
  logic          dir_nxt_s;

  assign cnt_mode_s  = cnt_mode_e'(count_mode);
  assign ld_mode_s   = load_mode_e'(load_mode);

  assign at_zero_s   = (carrier_r == ZERO_C);
  assign at_period_s = (carrier_r == period_act_r);
  assign over_s      = (carrier_r > period_act_r);
  assign wr_acc_s    = wr_valid & wr_ready_r;

  // A channel that is off or frozen has no load events to wait for.
  assign force_xfer_s = ~pwm_onoff | (cnt_mode_s == CNT_HOLD);

  // Shadow->active transfer decision on the current registered carrier.
  always_comb begin
    xfer_s = 1'b0;
    if (pending_r) begin
      xfer_s = force_xfer_s | load_cond(ld_mode_s, at_zero_s, at_period_s);
    end else begin
      xfer_s = 1'b0;
    end
  end

  // Next carrier/direction; carrier above period_act recovers without wrapping.
  always_comb begin
    carrier_nxt_s = carrier_r;
    dir_nxt_s     = dir_r;
    if (!pwm_onoff) begin
      carrier_nxt_s = ZERO_C;
      dir_nxt_s     = 1'b0;
    end else begin
      case (cnt_mode_s)
        CNT_UP: begin
          dir_nxt_s = 1'b0;
          if (at_period_s || over_s) begin
            carrier_nxt_s = ZERO_C;
          end else begin
            carrier_nxt_s = carrier_r + ONE_C;
          end
        end
        CNT_DOWN: begin
          dir_nxt_s = 1'b1;
          if (at_zero_s || over_s) begin
            carrier_nxt_s = period_act_r;
          end else begin
            carrier_nxt_s = carrier_r - ONE_C;
          end
        end
        CNT_UPDOWN: begin
          if (over_s || (period_act_r == ZERO_C)) begin
            carrier_nxt_s = ZERO_C;
            dir_nxt_s     = 1'b0;
          end else if (at_period_s) begin
            carrier_nxt_s = carrier_r - ONE_C;
            dir_nxt_s     = 1'b1;
          end else if (at_zero_s) begin
            carrier_nxt_s = ONE_C;
            dir_nxt_s     = 1'b0;
          end else if (dir_r) begin
            carrier_nxt_s = carrier_r - ONE_C;
            dir_nxt_s     = 1'b1;
          end else begin
            carrier_nxt_s = carrier_r + ONE_C;
            dir_nxt_s     = 1'b0;
          end
        end
        CNT_HOLD: begin
          carrier_nxt_s = carrier_r;
          dir_nxt_s     = dir_r;
        end
        default: begin
          carrier_nxt_s = carrier_r;
          dir_nxt_s     = dir_r;
        end
      endcase
    end
  end

  // Carrier and direction registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      carrier_r <= ZERO_C;
      dir_r     <= 1'b0;
    end else begin
      carrier_r <= carrier_nxt_s;
      dir_r     <= dir_nxt_s;
    end
  end

  // Write handshake, shadow capture and shadow->active transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      period_sh_r   <= ZERO_C;
      compare_sh_r  <= ZERO_C;
      period_act_r  <= ZERO_C;
      compare_act_r <= ZERO_C;
      pending_r     <= 1'b0;
      wr_ready_r    <= 1'b1;
      load_evt_r    <= 1'b0;
    end else begin
      if (wr_acc_s) begin
        period_sh_r  <= period_in;
        compare_sh_r <= compare_in;
        pending_r    <= 1'b1;
        wr_ready_r   <= 1'b0;
      end else if (xfer_s) begin
        period_act_r  <= period_sh_r;
        compare_act_r <= compare_sh_r;
        pending_r     <= 1'b0;
      end else if (load_evt_r) begin
        wr_ready_r <= 1'b1;
      end else begin
        pending_r <= pending_r;
      end
      load_evt_r <= xfer_s;
    end
  end

  compare_16bits #(
    .W (CW)
  ) u_cmp (
    .a  (carrier_r),
    .b  (compare_act_r),
    .lt (cmp_lt_s)
  );

  // Registered, enable-gated comparator output.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_r <= 1'b0;
    end else begin
      pwm_r <= pwm_onoff & cmp_lt_s;
    end
  end

  assign carrier     = carrier_r;
  assign dir         = dir_r;
  assign compare_act = compare_act_r;
  assign wr_ready    = wr_ready_r;
  assign load_evt    = load_evt_r;
  assign pwm         = pwm_r;
  assign evt_zero    = at_zero_s;
  assign evt_period  = at_period_s;

endmodule

// File: tb/tb_pwm_carrier_sched.sv
// Scenario bench for pwm_carrier_sched: per-cycle expectations are queued
// with the stimulus and popped as each DUT cycle is observed.
module tb_pwm_carrier_sched;
  import pwm_carrier_sched_pkg::*;

  localparam int W = PWM_CW;

  logic          clk = 1'b0;
  logic          rst;
  _pwm_onoff     pwm_onoff;
  logic [1:0]    count_mode;
  logic [1:0]    load_mode;
  logic          wr_valid;
  logic          wr_ready;
  logic [W-1:0]  period_in;
  logic [W-1:0]  compare_in;
  logic [W-1:0]  carrier;
  logic [W-1:0]  compare_act;
  logic          dir;
  logic          evt_zero;
  logic          evt_period;
  logic          load_evt;
  logic          pwm;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0] c;
    logic         d;
    logic         p;
    logic         le;
    logic         wr;
    logic         ez;
    logic         ep;
    logic [W-1:0] cmp;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  pwm_carrier_sched dut (
    .clk         (clk),
    .rst         (rst),
    .pwm_onoff   (pwm_onoff),
    .count_mode  (count_mode),
    .load_mode   (load_mode),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .period_in   (period_in),
    .compare_in  (compare_in),
    .carrier     (carrier),
    .compare_act (compare_act),
    .dir         (dir),
    .evt_zero    (evt_zero),
    .evt_period  (evt_period),
    .load_evt    (load_evt),
    .pwm         (pwm)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void push(input int c, input int d, input int p, input int le,
                               input int wr, input int ez, input int ep, input int cmp);
    exp_t e;
    e.c   = W'(c);
    e.d   = d[0];
    e.p   = p[0];
    e.le  = le[0];
    e.wr  = wr[0];
    e.ez  = ez[0];
    e.ep  = ep[0];
    e.cmp = W'(cmp);
    sb.push_back(e);
  endfunction

  task automatic do_reset();
    rst        = 1'b1;
    pwm_onoff  = 1'b0;
    count_mode = CNT_UP;
    load_mode  = LD_IMM;
    wr_valid   = 1'b0;
    period_in  = '0;
    compare_in = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Enable UP counting and program period/compare immediately.
  task automatic program_imm(input int per, input int cmpv);
    pwm_onoff  = 1'b1;
    count_mode = CNT_UP;
    load_mode  = LD_IMM;
    wr_valid   = 1'b1;
    period_in  = W'(per);
    compare_in = W'(cmpv);
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (carrier !== {W{1'b0}}) begin bad++; $display("FAIL reset.carrier got=%0d exp=0", carrier); end
    total++; if (dir !== 1'b0) begin bad++; $display("FAIL reset.dir got=%0b exp=0", dir); end
    total++; if (compare_act !== {W{1'b0}}) begin bad++; $display("FAIL reset.compare_act got=%0d exp=0", compare_act); end
    total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL reset.wr_ready got=%0b exp=1", wr_ready); end
    total++; if (load_evt !== 1'b0) begin bad++; $display("FAIL reset.load_evt got=%0b exp=0", load_evt); end
    total++; if (pwm !== 1'b0) begin bad++; $display("FAIL reset.pwm got=%0b exp=0", pwm); end
    total++; if (evt_zero !== 1'b1) begin bad++; $display("FAIL reset.evt_zero got=%0b exp=1", evt_zero); end
    total++; if (evt_period !== 1'b1) begin bad++; $display("FAIL reset.evt_period got=%0b exp=1", evt_period); end
  endtask

  task automatic test_up_imm();
    exp_t e;
    do_reset();
    program_imm(4, 2);
    push(0,0,0,0,0,1,1,0); push(0,0,0,1,0,1,0,2); push(1,0,1,0,1,0,0,2); push(2,0,1,0,1,0,0,2);
    push(3,0,0,0,1,0,0,2); push(4,0,0,0,1,0,1,2); push(0,0,0,0,1,1,0,2); push(1,0,1,0,1,0,0,2);
    for (int k = 1; sb.size() > 0; k++) begin
      step();
      if (k == 1) wr_valid = 1'b0;
      e = sb.pop_front();
      total++; if (carrier !== e.c) begin bad++; $display("FAIL up_imm.carrier cyc=%0d got=%0d exp=%0d", k, carrier, e.c); end
      total++; if (dir !== e.d) begin bad++; $display("FAIL up_imm.dir cyc=%0d got=%0b exp=%0b", k, dir, e.d); end
      total++; if (pwm !== e.p) begin bad++; $display("FAIL up_imm.pwm cyc=%0d got=%0b exp=%0b", k, pwm, e.p); end
      total++; if (load_evt !== e.le) begin bad++; $display("FAIL up_imm.load_evt cyc=%0d got=%0b exp=%0b", k, load_evt, e.le); end
      total++; if (wr_ready !== e.wr) begin bad++; $display("FAIL up_imm.wr_ready cyc=%0d got=%0b exp=%0b", k, wr_ready, e.wr); end
      total++; if (evt_zero !== e.ez) begin bad++; $display("FAIL up_imm.evt_zero cyc=%0d got=%0b exp=%0b", k, evt_zero, e.ez); end
      total++; if (evt_period !== e.ep) begin bad++; $display("FAIL up_imm.evt_period cyc=%0d got=%0b exp=%0b", k, evt_period, e.ep); end
      total++; if (compare_act !== e.cmp) begin bad++; $display("FAIL up_imm.compare_act cyc=%0d got=%0d exp=%0d", k, compare_act, e.cmp); end
    end
  endtask

  task automatic test_updown();
    exp_t e;
    do_reset();
    program_imm(3, 2);
    count_mode = CNT_UPDOWN;
    push(0,0,0,0,0,1,1,0); push(0,0,0,1,0,1,0,2); push(1,0,1,0,1,0,0,2); push(2,0,1,0,1,0,0,2);
    push(3,0,0,0,1,0,1,2); push(2,1,0,0,1,0,0,2); push(1,1,0,0,1,0,0,2); push(0,1,1,0,1,1,0,2);
    push(1,0,1,0,1,0,0,2); push(2,0,1,0,1,0,0,2); push(3,0,0,0,1,0,1,2);
    for (int k = 1; sb.size() > 0; k++) begin
      step();
      if (k == 1) wr_valid = 1'b0;
      e = sb.pop_front();
      total++; if (carrier !== e.c) begin bad++; $display("FAIL updown.carrier cyc=%0d got=%0d exp=%0d", k, carrier, e.c); end
      total++; if (dir !== e.d) begin bad++; $display("FAIL updown.dir cyc=%0d got=%0b exp=%0b", k, dir, e.d); end
      total++; if (pwm !== e.p) begin bad++; $display("FAIL updown.pwm cyc=%0d got=%0b exp=%0b", k, pwm, e.p); end
      total++; if (load_evt !== e.le) begin bad++; $display("FAIL updown.load_evt cyc=%0d got=%0b exp=%0b", k, load_evt, e.le); end
      total++; if (wr_ready !== e.wr) begin bad++; $display("FAIL updown.wr_ready cyc=%0d got=%0b exp=%0b", k, wr_ready, e.wr); end
      total++; if (evt_zero !== e.ez) begin bad++; $display("FAIL updown.evt_zero cyc=%0d got=%0b exp=%0b", k, evt_zero, e.ez); end
      total++; if (evt_period !== e.ep) begin bad++; $display("FAIL updown.evt_period cyc=%0d got=%0b exp=%0b", k, evt_period, e.ep); end
      total++; if (compare_act !== e.cmp) begin bad++; $display("FAIL updown.compare_act cyc=%0d got=%0d exp=%0d", k, compare_act, e.cmp); end
    end
  endtask

  // UP with period 9 up to carrier 6, then a deferred (LD_ZERO) or immediate reload to period 4.
  task automatic test_reload(input bit imm);
    exp_t  e;
    string tag;
    tag = imm ? "reload_imm" : "reload_zero";
    do_reset();
    program_imm(9, 5);
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 1) wr_valid = 1'b0;
    end
    load_mode  = imm ? LD_IMM : LD_ZERO;
    wr_valid   = 1'b1;
    period_in  = W'(4);
    compare_in = W'(2);
    if (imm) begin
      push(7,0,0,0,0,0,0,5); push(8,0,0,1,0,0,0,2); push(0,0,0,0,1,1,0,2);
      push(1,0,1,0,1,0,0,2); push(2,0,1,0,1,0,0,2);
    end else begin
      push(7,0,0,0,0,0,0,5); push(8,0,0,0,0,0,0,5); push(9,0,0,0,0,0,1,5); push(0,0,0,0,0,1,0,5);
      push(1,0,1,1,0,0,0,2); push(2,0,1,0,1,0,0,2); push(3,0,0,0,1,0,0,2); push(4,0,0,0,1,0,1,2);
      push(0,0,0,0,1,1,0,2); push(1,0,1,0,1,0,0,2);
    end
    for (int k = 1; sb.size() > 0; k++) begin
      step();
      if (k == 1) wr_valid = 1'b0;
      e = sb.pop_front();
      total++; if (carrier !== e.c) begin bad++; $display("FAIL %s.carrier cyc=%0d got=%0d exp=%0d", tag, k, carrier, e.c); end
      total++; if (dir !== e.d) begin bad++; $display("FAIL %s.dir cyc=%0d got=%0b exp=%0b", tag, k, dir, e.d); end
      total++; if (pwm !== e.p) begin bad++; $display("FAIL %s.pwm cyc=%0d got=%0b exp=%0b", tag, k, pwm, e.p); end
      total++; if (load_evt !== e.le) begin bad++; $display("FAIL %s.load_evt cyc=%0d got=%0b exp=%0b", tag, k, load_evt, e.le); end
      total++; if (wr_ready !== e.wr) begin bad++; $display("FAIL %s.wr_ready cyc=%0d got=%0b exp=%0b", tag, k, wr_ready, e.wr); end
      total++; if (evt_zero !== e.ez) begin bad++; $display("FAIL %s.evt_zero cyc=%0d got=%0b exp=%0b", tag, k, evt_zero, e.ez); end
      total++; if (evt_period !== e.ep) begin bad++; $display("FAIL %s.evt_period cyc=%0d got=%0b exp=%0b", tag, k, evt_period, e.ep); end
      total++; if (compare_act !== e.cmp) begin bad++; $display("FAIL %s.compare_act cyc=%0d got=%0d exp=%0d", tag, k, compare_act, e.cmp); end
    end
  endtask

  // DOWN with wr_valid held: the second write waits for wr_ready, then for carrier 0.
  task automatic test_back_to_back();
    exp_t e;
    do_reset();
    program_imm(5, 2);
    count_mode = CNT_DOWN;
    push(0,1,0,0,0,1,1,0); push(0,1,0,1,0,1,0,2); push(5,1,1,0,1,0,1,2); push(4,1,0,0,0,0,0,2);
    push(3,1,0,0,0,0,0,2); push(2,1,0,0,0,0,0,2); push(1,1,0,0,0,0,0,2); push(0,1,1,0,0,1,0,2);
    push(5,1,1,1,0,0,0,1); push(3,1,0,0,1,0,1,1); push(2,1,0,0,1,0,0,1); push(1,1,0,0,1,0,0,1);
    push(0,1,0,0,1,1,0,1); push(3,1,1,0,1,0,1,1);
    for (int k = 1; sb.size() > 0; k++) begin
      step();
      if (k == 1) begin
        load_mode  = LD_ZERO;
        period_in  = W'(3);
        compare_in = W'(1);
      end
      if (k == 4) wr_valid = 1'b0;
      e = sb.pop_front();
      total++; if (carrier !== e.c) begin bad++; $display("FAIL b2b.carrier cyc=%0d got=%0d exp=%0d", k, carrier, e.c); end
      total++; if (dir !== e.d) begin bad++; $display("FAIL b2b.dir cyc=%0d got=%0b exp=%0b", k, dir, e.d); end
      total++; if (pwm !== e.p) begin bad++; $display("FAIL b2b.pwm cyc=%0d got=%0b exp=%0b", k, pwm, e.p); end
      total++; if (load_evt !== e.le) begin bad++; $display("FAIL b2b.load_evt cyc=%0d got=%0b exp=%0b", k, load_evt, e.le); end
      total++; if (wr_ready !== e.wr) begin bad++; $display("FAIL b2b.wr_ready cyc=%0d got=%0b exp=%0b", k, wr_ready, e.wr); end
      total++; if (evt_zero !== e.ez) begin bad++; $display("FAIL b2b.evt_zero cyc=%0d got=%0b exp=%0b", k, evt_zero, e.ez); end
      total++; if (evt_period !== e.ep) begin bad++; $display("FAIL b2b.evt_period cyc=%0d got=%0b exp=%0b", k, evt_period, e.ep); end
      total++; if (compare_act !== e.cmp) begin bad++; $display("FAIL b2b.compare_act cyc=%0d got=%0d exp=%0d", k, compare_act, e.cmp); end
    end
  endtask

  // period 0 with compare 7: carrier pinned at 0, pwm high until the channel is switched off.
  task automatic test_period_zero();
    exp_t e;
    do_reset();
    program_imm(0, 7);
    push(0,0,0,0,0,1,1,0); push(0,0,0,1,0,1,1,7); push(0,0,1,0,1,1,1,7);
    push(0,0,1,0,1,1,1,7); push(0,0,0,0,1,1,1,7); push(0,0,0,0,1,1,1,7);
    for (int k = 1; sb.size() > 0; k++) begin
      step();
      if (k == 1) wr_valid = 1'b0;
      if (k == 4) pwm_onoff = 1'b0;
      e = sb.pop_front();
      total++; if (carrier !== e.c) begin bad++; $display("FAIL pzero.carrier cyc=%0d got=%0d exp=%0d", k, carrier, e.c); end
      total++; if (dir !== e.d) begin bad++; $display("FAIL pzero.dir cyc=%0d got=%0b exp=%0b", k, dir, e.d); end
      total++; if (pwm !== e.p) begin bad++; $display("FAIL pzero.pwm cyc=%0d got=%0b exp=%0b", k, pwm, e.p); end
      total++; if (load_evt !== e.le) begin bad++; $display("FAIL pzero.load_evt cyc=%0d got=%0b exp=%0b", k, load_evt, e.le); end
      total++; if (wr_ready !== e.wr) begin bad++; $display("FAIL pzero.wr_ready cyc=%0d got=%0b exp=%0b", k, wr_ready, e.wr); end
      total++; if (evt_zero !== e.ez) begin bad++; $display("FAIL pzero.evt_zero cyc=%0d got=%0b exp=%0b", k, evt_zero, e.ez); end
      total++; if (evt_period !== e.ep) begin bad++; $display("FAIL pzero.evt_period cyc=%0d got=%0b exp=%0b", k, evt_period, e.ep); end
      total++; if (compare_act !== e.cmp) begin bad++; $display("FAIL pzero.compare_act cyc=%0d got=%0d exp=%0d", k, compare_act, e.cmp); end
    end
  endtask

  // HOLD forces a pending transfer; then rst lands with a write still pending.
  task automatic test_hold_reset();
    exp_t e;
    do_reset();
    program_imm(9, 5);
    push(0,0,0,0,0,1,1,0); push(0,0,0,1,0,1,0,5); push(1,0,1,0,1,0,0,5); push(2,0,1,0,1,0,0,5);
    push(2,0,1,0,0,0,0,5); push(2,0,1,1,0,0,0,3); push(2,0,1,0,1,0,0,3); push(3,0,1,0,0,0,0,3);
    push(0,0,0,0,1,1,1,0); push(0,0,0,0,1,1,1,0);
    for (int k = 1; sb.size() > 0; k++) begin
      step();
      case (k)
        1: wr_valid = 1'b0;
        4: begin
          count_mode = CNT_HOLD; load_mode = LD_PERIOD;
          wr_valid = 1'b1; period_in = W'(6); compare_in = W'(3);
        end
        5: wr_valid = 1'b0;
        7: begin
          count_mode = CNT_UP; load_mode = LD_ZERO;
          wr_valid = 1'b1; period_in = W'(8); compare_in = W'(4);
        end
        8: begin wr_valid = 1'b0; rst = 1'b1; end
        9: rst = 1'b0;
        default: ;
      endcase
      e = sb.pop_front();
      total++; if (carrier !== e.c) begin bad++; $display("FAIL hold_rst.carrier cyc=%0d got=%0d exp=%0d", k, carrier, e.c); end
      total++; if (dir !== e.d) begin bad++; $display("FAIL hold_rst.dir cyc=%0d got=%0b exp=%0b", k, dir, e.d); end
      total++; if (pwm !== e.p) begin bad++; $display("FAIL hold_rst.pwm cyc=%0d got=%0b exp=%0b", k, pwm, e.p); end
      total++; if (load_evt !== e.le) begin bad++; $display("FAIL hold_rst.load_evt cyc=%0d got=%0b exp=%0b", k, load_evt, e.le); end
      total++; if (wr_ready !== e.wr) begin bad++; $display("FAIL hold_rst.wr_ready cyc=%0d got=%0b exp=%0b", k, wr_ready, e.wr); end
      total++; if (evt_zero !== e.ez) begin bad++; $display("FAIL hold_rst.evt_zero cyc=%0d got=%0b exp=%0b", k, evt_zero, e.ez); end
      total++; if (evt_period !== e.ep) begin bad++; $display("FAIL hold_rst.evt_period cyc=%0d got=%0b exp=%0b", k, evt_period, e.ep); end
      total++; if (compare_act !== e.cmp) begin bad++; $display("FAIL hold_rst.compare_act cyc=%0d got=%0d exp=%0d", k, compare_act, e.cmp); end
    end
  endtask

  initial begin
    test_reset();
    test_up_imm();
    test_updown();
    test_reload(1'b0);
    test_reload(1'b1);
    test_back_to_back();
    test_period_zero();
    test_hold_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_carrier_sched.md
Name: pwm_carrier_sched

Overview:
Per-channel PWM carrier generator and compare scheduler that drives the team's compare_16bits comparator.
- Produces the carrier count in up, down or up-down mode.
- Holds double-buffered (shadow/active) period and compare registers and transfers shadow to active only at programmed load events.
- Gates the comparator output with the channel on/off control.
- Sits between the AXI4-Lite register bank and the gate-drive output logic.

Parameters:
CW, `PWMCOUNT_WIDTH (16), carrier/period/compare width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
pwm_onoff  in  _pwm_onoff  channel enable; deasserted = channel off
count_mode  in  2  0 up, 1 down, 2 up-down, 3 hold
load_mode  in  2  shadow->active transfer at: 0 zero, 1 period, 2 zero or period, 3 immediate
wr_valid  in  1  shadow write request
wr_ready  out  1  shadow register free
period_in  in  CW  new period value
compare_in  in  CW  new compare value
carrier  out  CW  current carrier count (registered)
compare_act  out  CW  active compare value
dir  out  1  1 = counting down
evt_zero  out  1  carrier == 0
evt_period  out  1  carrier == period_act
load_evt  out  1  shadow transferred this cycle (1-cycle pulse)
pwm  out  1  comparator output, gated by pwm_onoff

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: carrier 0, dir 0, period_act 0, compare_act 0, shadow registers 0, pending 0, wr_ready 1, load_evt 0, pwm 0.
- Write handshake:
  - A write is accepted when wr_valid && wr_ready. The cycle after acceptance, period_in/compare_in are in shadow, pending=1 and wr_ready=0.
  - wr_ready returns to 1 the cycle after the transfer.
  - wr_valid held while wr_ready=0 is ignored. It is not queued.
- Transfer:
  - When pending=1 and the load condition selected by load_mode holds on the current registered carrier, active <= shadow, pending <= 0, load_evt=1 for that cycle.
  - Mode 3 transfers on the cycle after acceptance.
  - While pwm_onoff is off or count_mode=3, a pending transfer occurs on the next cycle regardless of load_mode.
- Counter states:
  - IDLE (pwm_onoff off): carrier <= 0, dir <= 0.
  - HOLD (count_mode 3): carrier and dir frozen.
  - UP: carrier == period_act ? 0 : carrier+1.
  - DOWN: carrier == 0 ? period_act : carrier-1.
  - UPDOWN: counts up to period_act, dir <= 1, then down to 0, dir <= 0. The peak and the valley each last exactly 1 cycle, so the sequence for period 3 is 0,1,2,3,2,1,0,1.
  - Leaving IDLE: counting starts from carrier 0, dir 0 (DOWN starts by loading period_act).
  - Changing count_mode mid-count continues from the current carrier. UP/DOWN force dir to match the mode. UPDOWN keeps the current dir.
- Boundaries:
  - period_act=0: carrier stays 0; evt_zero and evt_period are both 1 every cycle.
  - Immediate load with carrier > new period_act: the next carrier is 0 (UP/UPDOWN, dir <= 0) or the new period_act (DOWN). No wrap through the full CW range.
  - No arithmetic overflow is possible; all values are unsigned CW-bit.
- Events: evt_zero and evt_period are combinational decodes of the registered carrier and period_act, valid in the same cycle as carrier.
- PWM output:
  - pwm is registered: pwm <= onoff && (carrier < compare_act), using the comparator on the current carrier. Latency is 1 cycle after carrier.
  - compare_act = 0 gives a constant 0.
  - compare_act > period_act gives a constant 1 while enabled.
  - Turning pwm_onoff off forces pwm=0 on the next cycle.
- Reset mid-operation discards any pending shadow and returns all outputs to their reset values on the next edge.

Decomposition:
- Shared PWM package:
  - _pwm_onoff typedef.
  - Enum types for count_mode (CNT_UP, CNT_DOWN, CNT_UPDOWN, CNT_HOLD) and load_mode (LD_ZERO, LD_PERIOD, LD_BOTH, LD_IMM).
  - `PWMCOUNT_WIDTH stays the global width define.
- Sub-module: one instance of compare_16bits for the comparison.
- The top-level register stage around it provides the registered pwm; the shadow/active logic and counter stay in this module.

Test Plan:
- Reset, then onoff on, UP, write period=4/compare=2, LD_IMM -> carrier 0,1,2,3,4,0; pwm (1 cycle delayed) 1,1,0,0,0,1; load_evt one pulse; wr_ready 0 for exactly 2 cycles.
- UPDOWN, period=3 -> carrier 0,1,2,3,2,1,0,1; dir rises the cycle after carrier=3 and falls the cycle after carrier=0; evt_period high 1 cycle per period.
- UP, period=9, carrier=6, write period=4 with LD_ZERO -> active unchanged until carrier wraps 9->0; load_evt at carrier=0; next sequence 0..4. Repeat with LD_IMM -> next carrier 0.
- DOWN, period=5, write while pending with wr_valid held -> second write accepted only after load_evt; carrier 5,4,3,2,1,0,5.
- period=0 -> carrier constant 0, evt_zero=evt_period=1; compare=7 -> pwm=1; onoff off -> pwm=0 next cycle, carrier 0.
- rst asserted mid-count with pending=1 -> next cycle all outputs at reset values, wr_ready=1, no load_evt.
